// File: rtl/hci_core_protocol_checker_pkg.sv
// Shared definitions for the HCI core-side protocol checker.
//   NUM_RULES       : number of per-channel rules checked
//   HCI_RULE_*      : bit index of each rule inside a rule vector
//   hci_rule_vec_t  : one bit per rule
//   clog2_min1()    : $clog2 clamped to at least one bit, for index widths
package hci_package;

  localparam int NUM_RULES = 7;

  localparam int HCI_RULE_RQ3      = 0;
  localparam int HCI_RULE_RQ4      = 1;
  localparam int HCI_RULE_RSP3     = 2;
  localparam int HCI_RULE_RSP5     = 3;
  localparam int HCI_RULE_ORPHAN   = 4;
  localparam int HCI_RULE_OVERFLOW = 5;
  localparam int HCI_RULE_TIMEOUT  = 6;

  typedef logic [NUM_RULES-1:0] hci_rule_vec_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/hci_core_protocol_checker_ch.sv
// Per-channel monitor: keeps previous-cycle samples of the handshakes and
// payloads, the outstanding-transaction counter and the response timeout
// counter, and evaluates every rule for the current cycle.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i/gnt_i           : request handshake
//   r_valid_i/r_ready_i   : response handshake
//   rq_payload_i          : packed request payload
//   rsp_payload_i         : packed response payload
//   viol_o                : raw (unmasked) violations seen this cycle
//   outstanding_o         : registered outstanding count
module hci_core_protocol_checker_ch
  import hci_package::*;
#(
  parameter int RQ_W            = 64,
  parameter int RSP_W           = 48,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int OUT_W           = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 gnt_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic [RQ_W-1:0]      rq_payload_i,
  input  logic [RSP_W-1:0]     rsp_payload_i,
  output logic [NUM_RULES-1:0] viol_o,
  output logic [OUT_W-1:0]     outstanding_o
);

  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  logic              req_q, gnt_q, rv_q, rr_q;
  logic [RQ_W-1:0]   rq_q;
  logic [RSP_W-1:0]  rsp_q;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [TO_W-1:0]   to_q, to_d;
  hci_rule_vec_t     viol;
  logic              rq_hs, rsp_hs, out_zero, out_full, dec;

  always_comb begin
    rq_hs    = req_i & gnt_i;
    rsp_hs   = r_valid_i & r_ready_i;
    out_zero = (out_q == '0);
    out_full = (out_q == OUT_MAX);
    // A response with nothing outstanding is an orphan and must not
    // underflow the counter.
    dec      = rsp_hs & ~out_zero;

    viol                    = '0;
    viol[HCI_RULE_RQ3]      = req_q & ~gnt_q & (rq_payload_i != rq_q);
    viol[HCI_RULE_RQ4]      = req_q & ~gnt_q & ~req_i;
    viol[HCI_RULE_RSP3]     = rv_q & ~rr_q & (rsp_payload_i != rsp_q);
    viol[HCI_RULE_RSP5]     = rv_q & ~rr_q & ~r_valid_i;
    viol[HCI_RULE_ORPHAN]   = rsp_hs & out_zero;
    viol[HCI_RULE_OVERFLOW] = rq_hs & out_full & ~rsp_hs;

    out_d = out_q;
    if (rq_hs && !dec && !out_full) begin
      out_d = out_q + 1'b1;
    end else if (dec && !rq_hs) begin
      out_d = out_q - 1'b1;
    end

    // The timer runs only while something is outstanding and no response
    // retires this cycle; it parks at the limit so the rule fires on the
    // single cycle where the limit is first reached.
    to_d = '0;
    if (TIMEOUT_CYCLES != 0 && !rsp_hs && !out_zero) begin
      to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    end
    viol[HCI_RULE_TIMEOUT] = (TIMEOUT_CYCLES != 0) && (to_d == TO_MAX) && (to_q != TO_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
      gnt_q <= 1'b0;
      rv_q  <= 1'b0;
      rr_q  <= 1'b0;
      rq_q  <= '0;
      rsp_q <= '0;
      out_q <= '0;
      to_q  <= '0;
    end else begin
      req_q <= req_i;
      gnt_q <= gnt_i;
      rv_q  <= r_valid_i;
      rr_q  <= r_ready_i;
      rq_q  <= rq_payload_i;
      rsp_q <= rsp_payload_i;
      out_q <= out_d;
      to_q  <= to_d;
    end
  end

  assign viol_o        = viol;
  assign outstanding_o = out_q;

endmodule

// File: rtl/hci_core_protocol_checker.sv
// Passive HCI core-side protocol checker over N_CH channels. Collects the
// per-channel rule violations, masks them with rule_en_i, keeps them as
// sticky error bits, captures the first error and counts violating cycles.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clear_i         : clears errors, counter and first-error capture
//   rule_en_i       : per-rule enable, shared by all channels
//   req_i .. r_ready_i, rq_payload_i, rsp_payload_i : monitored channels
//   err_o           : sticky errors, channel c rule r at bit c*NUM_RULES+r
//   err_any_o       : OR of err_o
//   first_ch_o / first_rule_o : location of the first error
//   err_cnt_o       : saturating count of cycles with a new violation
//   outstanding_o   : per-channel outstanding counts, channel c at slice c
module hci_core_protocol_checker
  import hci_package::*;
#(
  parameter int N_CH            = 4,
  parameter int RQ_W            = 64,
  parameter int RSP_W           = 48,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CNT_W           = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          clear_i,
  input  logic [NUM_RULES-1:0]                          rule_en_i,
  input  logic [N_CH-1:0]                               req_i,
  input  logic [N_CH-1:0]                               gnt_i,
  input  logic [N_CH-1:0]                               r_valid_i,
  input  logic [N_CH-1:0]                               r_ready_i,
  input  logic [N_CH*RQ_W-1:0]                          rq_payload_i,
  input  logic [N_CH*RSP_W-1:0]                         rsp_payload_i,
  output logic [N_CH*NUM_RULES-1:0]                     err_o,
  output logic                                          err_any_o,
  output logic [clog2_min1(N_CH)-1:0]                   first_ch_o,
  output logic [$clog2(NUM_RULES)-1:0]                  first_rule_o,
  output logic [CNT_W-1:0]                              err_cnt_o,
  output logic [N_CH*$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int CH_W   = clog2_min1(N_CH);
  localparam int RULE_W = $clog2(NUM_RULES);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [N_CH*NUM_RULES-1:0] viol, new_err, err_q, err_d;
  logic [CH_W-1:0]           first_ch_q, first_ch_d, enc_ch;
  logic [RULE_W-1:0]         first_rule_q, first_rule_d, enc_rule;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      any_new, err_any;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    hci_core_protocol_checker_ch #(
      .RQ_W            (RQ_W),
      .RSP_W           (RSP_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
      .OUT_W           (OUT_W)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i[gi]),
      .gnt_i         (gnt_i[gi]),
      .r_valid_i     (r_valid_i[gi]),
      .r_ready_i     (r_ready_i[gi]),
      .rq_payload_i  (rq_payload_i[gi*RQ_W +: RQ_W]),
      .rsp_payload_i (rsp_payload_i[gi*RSP_W +: RSP_W]),
      .viol_o        (viol[gi*NUM_RULES +: NUM_RULES]),
      .outstanding_o (outstanding_o[gi*OUT_W +: OUT_W])
    );
  end

  assign err_any = |err_q;

  always_comb begin
    new_err = '0;
    for (int c = 0; c < N_CH; c++) begin
      new_err[c*NUM_RULES +: NUM_RULES] = viol[c*NUM_RULES +: NUM_RULES] & rule_en_i;
    end
    any_new = |new_err;

    // Scan from the highest position down so the lowest channel, then the
    // lowest rule, is the last assignment and wins.
    enc_ch   = '0;
    enc_rule = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
        if (new_err[c*NUM_RULES + r]) begin
          enc_ch   = CH_W'(c);
          enc_rule = RULE_W'(r);
        end
      end
    end

    // A violation arriving together with clear_i survives the clear.
    err_d = clear_i ? new_err : (err_q | new_err);

    first_ch_d   = first_ch_q;
    first_rule_d = first_rule_q;
    if (clear_i) begin
      first_ch_d   = '0;
      first_rule_d = '0;
    end
    if ((clear_i || !err_any) && any_new) begin
      first_ch_d   = enc_ch;
      first_rule_d = enc_rule;
    end

    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d    = '0;
      cnt_d[0] = any_new;
    end else if (any_new && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q        <= '0;
      first_ch_q   <= '0;
      first_rule_q <= '0;
      cnt_q        <= '0;
    end else begin
      err_q        <= err_d;
      first_ch_q   <= first_ch_d;
      first_rule_q <= first_rule_d;
      cnt_q        <= cnt_d;
    end
  end

  assign err_o        = err_q;
  assign err_any_o    = err_any;
  assign first_ch_o   = first_ch_q;
  assign first_rule_o = first_rule_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hci_core_protocol_checker.sv
// Directed bench for hci_core_protocol_checker: a one-cycle-per-row vector
// table for the rule, masking, clear and counter behaviour, followed by
// hand-written sequences for timeout, clear-with-outstanding, reset and
// counter saturation.
module tb_hci_core_protocol_checker;

  localparam int N_CH = 4;
  localparam int RQ_W = 16;
  localparam int RSP_W = 16;
  localparam int MAXO = 3;
  localparam int TOC = 4;
  localparam int CNT_W = 4;

  logic                clk_i = 1'b0;
  logic                rst_i, clear_i;
  logic [6:0]          rule_en_i;
  logic [3:0]          req_i, gnt_i, r_valid_i, r_ready_i;
  logic [4*RQ_W-1:0]   rq_payload_i;
  logic [4*RSP_W-1:0]  rsp_payload_i;
  logic [27:0]         err_o;
  logic                err_any_o;
  logic [1:0]          first_ch_o;
  logic [2:0]          first_rule_o;
  logic [CNT_W-1:0]    err_cnt_o;
  logic [7:0]          outstanding_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  hci_core_protocol_checker #(
    .N_CH(N_CH), .RQ_W(RQ_W), .RSP_W(RSP_W),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOC), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .rule_en_i(rule_en_i),
    .req_i(req_i), .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_ready_i(r_ready_i),
    .rq_payload_i(rq_payload_i), .rsp_payload_i(rsp_payload_i),
    .err_o(err_o), .err_any_o(err_any_o), .first_ch_o(first_ch_o),
    .first_rule_o(first_rule_o), .err_cnt_o(err_cnt_o), .outstanding_o(outstanding_o)
  );

  typedef struct {
    logic [3:0]  req, gnt, rv, rr;
    logic [15:0] rq, rsp;
    logic [6:0]  en;
    logic        clr;
    logic [27:0] err;
    logic [7:0]  out;
    logic [3:0]  cnt;
    logic [1:0]  fch;
    logic [2:0]  frule;
  } vec_t;

  vec_t tv [27];

  function automatic logic [27:0] eb(input int c, input int r);
    logic [27:0] v;
    v = '0;
    v[c*7 + r] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] req, gnt, rv, rr,
                              input logic [15:0] rq, rsp, input logic [6:0] en,
                              input logic clr, input logic [27:0] err,
                              input logic [7:0] out, input logic [3:0] cnt,
                              input logic [1:0] fch, input logic [2:0] frule);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rr = rr; v.rq = rq; v.rsp = rsp;
    v.en = en; v.clr = clr; v.err = err; v.out = out; v.cnt = cnt;
    v.fch = fch; v.frule = frule;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, gnt, rv, rr);
    req_i = req; gnt_i = gnt; r_valid_i = rv; r_ready_i = rr;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    clear_i = 1'b0;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  localparam logic [6:0] EN = 7'h3F;  // timeout masked in the table
  localparam logic [6:0] EA = 7'h7F;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; rule_en_i = EN;
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    rq_payload_i = '0; rsp_payload_i = '0;

    //           req   gnt   rv    rr    rq      rsp     en  clr err                 out    cnt fch frule
    tv[0]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 16'h00, 16'h00, EN, 0, '0,                 8'h00, 0, 0, 0);
    tv[1]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 16'hA5, 16'h00, EN, 0, '0,                 8'h00, 0, 0, 0);
    tv[2]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 16'hA6, 16'h00, EN, 0, eb(1,0),            8'h00, 1, 1, 0);
    tv[3]  = mk(4'h2, 4'h2, 4'h0, 4'h0, 16'hA6, 16'h00, EN, 0, eb(1,0),            8'h04, 1, 1, 0);
    tv[4]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 16'hA6, 16'h00, EN, 1, '0,                 8'h04, 0, 0, 0);
    tv[5]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 16'hA5, 16'h00, 7'h3E, 0, '0,              8'h04, 0, 0, 0);
    tv[6]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 16'hA6, 16'h00, 7'h3E, 0, '0,              8'h04, 0, 0, 0);
    tv[7]  = mk(4'h2, 4'h2, 4'h0, 4'h0, 16'hA6, 16'h00, EN, 0, '0,                 8'h08, 0, 0, 0);
    tv[8]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 16'hA6, 16'h00, EN, 0, '0,                 8'h08, 0, 0, 0);
    tv[9]  = mk(4'h0, 4'h0, 4'h4, 4'h0, 16'hA6, 16'h11, EN, 0, eb(0,1),            8'h08, 1, 0, 1);
    tv[10] = mk(4'h0, 4'h0, 4'h0, 4'h0, 16'h00, 16'h11, EN, 0, eb(0,1)|eb(2,3),    8'h08, 2, 0, 1);
    tv[11] = mk(4'h0, 4'h0, 4'h0, 4'h0, 16'h00, 16'h00, EN, 1, '0,                 8'h08, 0, 0, 0);
    tv[12] = mk(4'h8, 4'h8, 4'h0, 4'h0, 16'h00, 16'h00, EN, 0, '0,                 8'h48, 0, 0, 0);
    tv[13] = mk(4'h8, 4'h8, 4'h0, 4'h0, 16'h00, 16'h00, EN, 0, '0,                 8'h88, 0, 0, 0);
    tv[14] = mk(4'h8, 4'h8, 4'h0, 4'h0, 16'h00, 16'h00, EN, 0, '0,                 8'hC8, 0, 0, 0);
    tv[15] = mk(4'h8, 4'h8, 4'h0, 4'h0, 16'h00, 16'h00, EN, 0, eb(3,5),            8'hC8, 1, 3, 5);
    tv[16] = mk(4'h0, 4'h0, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, eb(3,5),            8'h88, 1, 3, 5);
    tv[17] = mk(4'h0, 4'h0, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, eb(3,5),            8'h48, 1, 3, 5);
    tv[18] = mk(4'h0, 4'h0, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, eb(3,5),            8'h08, 1, 3, 5);
    tv[19] = mk(4'h0, 4'h0, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, eb(3,5)|eb(3,4),    8'h08, 2, 3, 5);
    tv[20] = mk(4'h8, 4'h8, 4'h0, 4'h0, 16'h00, 16'h00, EN, 1, '0,                 8'h48, 0, 0, 0);
    tv[21] = mk(4'h8, 4'h8, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, '0,                 8'h48, 0, 0, 0);
    tv[22] = mk(4'h0, 4'h0, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, '0,                 8'h08, 0, 0, 0);
    tv[23] = mk(4'h8, 4'h8, 4'h8, 4'h8, 16'h00, 16'h00, EN, 0, eb(3,4),            8'h48, 1, 3, 4);
    tv[24] = mk(4'h0, 4'h0, 4'h1, 4'h0, 16'h00, 16'h22, EN, 1, '0,                 8'h48, 0, 0, 0);
    tv[25] = mk(4'h0, 4'h0, 4'h1, 4'h0, 16'h00, 16'h23, EN, 0, eb(0,2),            8'h48, 1, 0, 2);
    tv[26] = mk(4'h0, 4'h0, 4'h1, 4'h1, 16'h00, 16'h23, EN, 1, eb(0,4),            8'h48, 1, 0, 4);

    // Reset state
    step();
    step();
    chk("rst_err", 32'(err_o), 0);
    chk("rst_any", 32'(err_any_o), 0);
    chk("rst_out", 32'(outstanding_o), 0);
    chk("rst_cnt", 32'(err_cnt_o), 0);
    chk("rst_fch", 32'(first_ch_o), 0);
    chk("rst_frule", 32'(first_rule_o), 0);
    rst_i = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tv[i].req, tv[i].gnt, tv[i].rv, tv[i].rr);
      rq_payload_i  = {4{tv[i].rq}};
      rsp_payload_i = {4{tv[i].rsp}};
      rule_en_i     = tv[i].en;
      clear_i       = tv[i].clr;
      step();
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tv[i].err));
      chk($sformatf("v%0d_any", i), 32'(err_any_o), 32'(|tv[i].err));
      chk($sformatf("v%0d_out", i), 32'(outstanding_o), 32'(tv[i].out));
      chk($sformatf("v%0d_cnt", i), 32'(err_cnt_o), 32'(tv[i].cnt));
      chk($sformatf("v%0d_fch", i), 32'(first_ch_o), 32'(tv[i].fch));
      chk($sformatf("v%0d_frule", i), 32'(first_rule_o), 32'(tv[i].frule));
      $display("vec %0d: err=%07h out=%02h cnt=%0d first=%0d/%0d",
               i, err_o, outstanding_o, err_cnt_o, first_ch_o, first_rule_o);
    end
    clear_i = 1'b0;
    rq_payload_i = '0;
    rsp_payload_i = '0;

    // Timeout: one grant on ch2, no response; error visible 5 cycles later
    do_reset();
    chk("to_rst_out", 32'(outstanding_o), 0);
    rule_en_i = EA;
    drive(4'h4, 4'h4, 4'h0, 4'h0);
    step();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("to_c%0d", k), 32'(err_o[2*7+6]), (k >= 5) ? 32'd1 : 32'd0);
      $display("timeout cycle %0d: err=%07h", k, err_o);
      step();
    end
    chk("to_err", 32'(err_o), 32'(eb(2,6)));
    chk("to_cnt", 32'(err_cnt_o), 1);
    chk("to_out", 32'(outstanding_o), 32'h10);
    chk("to_first", 32'({first_ch_o, first_rule_o}), 32'({2'd2, 3'd6}));

    // Clear with ch1 holding 3 outstanding
    do_reset();
    rule_en_i = EN;
    drive(4'h2, 4'h2, 4'h1, 4'h1);
    step();
    drive(4'h2, 4'h2, 4'h0, 4'h0);
    step();
    step();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    chk("cl_pre_out", 32'(outstanding_o), 32'h0C);
    chk("cl_pre_err", 32'(err_o), 32'(eb(0,4)));
    chk("cl_pre_cnt", 32'(err_cnt_o), 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("cl_err", 32'(err_o), 0);
    chk("cl_cnt", 32'(err_cnt_o), 0);
    chk("cl_first", 32'({first_ch_o, first_rule_o}), 0);
    chk("cl_out", 32'(outstanding_o), 32'h0C);
    $display("clear: err=%07h out=%02h cnt=%0d", err_o, outstanding_o, err_cnt_o);
    do_reset();
    chk("rs_out", 32'(outstanding_o), 0);
    chk("rs_err", 32'(err_o), 0);
    $display("reset: err=%07h out=%02h cnt=%0d", err_o, outstanding_o, err_cnt_o);

    // Counter saturation: orphan responses on ch0 every cycle
    drive(4'h0, 4'h0, 4'h1, 4'h1);
    step();
    step();
    step();
    chk("sat_cnt3", 32'(err_cnt_o), 3);
    for (int k = 0; k < 17; k++) step();
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    chk("sat_cnt", 32'(err_cnt_o), 15);
    chk("sat_err", 32'(err_o), 32'(eb(0,4)));
    chk("sat_out", 32'(outstanding_o), 0);
    $display("saturate: cnt=%0d err=%07h", err_cnt_o, err_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
